// File: rtl/uart_rx_filtered.sv
// Glitch-tolerant 8N1 UART receiver: synchronised RX pin, 3-sample majority per bit,
// stop-bit check with framing-error pulse and line-break level.
module uart_rx_filtered #(
  parameter int unsigned CLK_PER_BIT = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_serial_line,
  output logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_frame_err,
  output logic       rx_break,
  output logic       rx_busy
);

  localparam int unsigned CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] CNT_HM1  = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_H    = CW'(CLK_PER_BIT / 2);
  localparam logic [CW-1:0] CNT_HP1  = CW'(CLK_PER_BIT / 2 + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [3:0]             bit_q, bit_d;
  logic [7:0]             shreg_q, shreg_d;
  logic                   samp_a_q, samp_a_d;
  logic                   samp_b_q, samp_b_d;
  logic [7:0]             data_q, data_d;
  logic                   ready_q, ready_d;
  logic                   ferr_q, ferr_d;
  logic                   brk_q, brk_d;
  logic                   busy_q, busy_d;
  logic                   s;
  logic                   maj;

  assign s   = sync_q[SYNC_STAGES-1];
  // Third vote is the live sample, so the bit value resolves on the cnt H+1 cycle.
  assign maj = (samp_a_q & samp_b_q) | (samp_a_q & s) | (samp_b_q & s);

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], rx_serial_line};
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    samp_a_d = samp_a_q;
    samp_b_d = samp_b_q;
    data_d   = data_q;
    ready_d  = 1'b0;
    ferr_d   = 1'b0;
    brk_d    = brk_q;

    unique case (state_q)
      IDLE: begin
        // The first low cycle is cnt 0 of the start bit.
        if (!s) begin
          state_d = START;
          cnt_d   = CW'(1);
          bit_d   = '0;
        end
      end

      START, DATA, STOP: begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        if (cnt_q == CNT_HM1) samp_a_d = s;
        if (cnt_q == CNT_H)   samp_b_d = s;

        if (cnt_q == CNT_HP1) begin
          if (state_q == START && maj) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (state_q == DATA) begin
            shreg_d = {maj, shreg_q[7:1]};
          end else if (state_q == STOP) begin
            cnt_d = '0;
            if (maj) begin
              data_d  = shreg_q;
              ready_d = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = WAIT_HIGH;
              if (shreg_q != '0) ferr_d = 1'b1;
              else               brk_d  = 1'b1;
            end
          end
        end

        if (cnt_q == CNT_LAST) begin
          bit_d = bit_q + 4'd1;
          if (state_q == START)                     state_d = DATA;
          else if (state_q == DATA && bit_q == 4'd8) state_d = STOP;
        end
      end

      WAIT_HIGH: begin
        if (!s) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          brk_d   = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '1;
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      samp_a_q <= 1'b1;
      samp_b_q <= 1'b1;
      data_q   <= '0;
      ready_q  <= 1'b0;
      ferr_q   <= 1'b0;
      brk_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      samp_a_q <= samp_a_d;
      samp_b_q <= samp_b_d;
      data_q   <= data_d;
      ready_q  <= ready_d;
      ferr_q   <= ferr_d;
      brk_q    <= brk_d;
      busy_q   <= busy_d;
    end
  end

  assign rx_ready     = ready_q;
  assign rx_data      = data_q;
  assign rx_frame_err = ferr_q;
  assign rx_break     = brk_q;
  assign rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_filtered.sv
// Directed bench for uart_rx_filtered: latency, false start, glitch, framing error,
// line break and mid-frame reset, all against hand-computed expectations.
module tb_uart_rx_filtered;

  localparam int unsigned C    = 16;
  localparam int unsigned H    = C / 2;
  localparam int unsigned SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_frame_err;
  logic       rx_break;
  logic       rx_busy;

  always #5 clk = ~clk;

  uart_rx_filtered #(
    .CLK_PER_BIT(C),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_serial_line(rx),
    .rx_ready      (rx_ready),
    .rx_data       (rx_data),
    .rx_frame_err  (rx_frame_err),
    .rx_break      (rx_break),
    .rx_busy       (rx_busy)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int          cyc = 0;
  int          n_ready = 0;
  int          n_ferr = 0;
  int          n_both = 0;
  int          n_wide = 0;
  int          ready_cyc = 0;
  logic        prev_ready = 1'b0;
  logic        prev_ferr = 1'b0;
  logic [7:0]  got_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: wait for the falling edge, then record pulse activity.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (rx_ready) begin
      n_ready++;
      ready_cyc = cyc;
      got_q.push_back(rx_data);
    end
    if (rx_frame_err) n_ferr++;
    if (rx_ready && rx_frame_err) n_both++;
    if ((rx_ready && prev_ready) || (rx_frame_err && prev_ferr)) n_wide++;
    prev_ready = rx_ready;
    prev_ferr  = rx_frame_err;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_lvl, input int nbits,
                            input int g_bit, input int g_cnt);
    logic [9:0] fr;
    fr = {stop_lvl, d, 1'b0};
    for (int b = 0; b < nbits; b++) begin
      for (int k = 0; k < C; k++) begin
        rx = fr[b] ^ ((b == g_bit) && (k == g_cnt));
        tick();
      end
    end
  endtask

  int x0, t0, r0, f0;

  initial begin
    rx    = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_ready", rx_ready, 0);
    check("reset_data", rx_data, 8'h00);
    check("reset_ferr", rx_frame_err, 0);
    check("reset_break", rx_break, 0);
    check("reset_busy", rx_busy, 0);
    rst_n = 1'b1;
    idle(4);

    // 0x55: one pulse, 9C+H+2 after s falls plus synchroniser delay
    x0 = cyc; r0 = n_ready; f0 = n_ferr;
    send_frame(8'h55, 1'b1, 10, -1, 0);
    idle(2 * C);
    check("b55_count", n_ready - r0, 1);
    check("b55_data", rx_data, 8'h55);
    check("b55_latency", ready_cyc - x0, 9 * C + H + 2 + SYNC);
    check("b55_ferr", n_ferr - f0, 0);
    check("b55_break", rx_break, 0);

    // 4-cycle low blip: false start
    x0 = cyc; r0 = n_ready; f0 = n_ferr;
    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    while (cyc - x0 < 3) tick();
    check("false_busy_hi", rx_busy, 1);
    while (cyc - x0 < 11) tick();
    check("false_busy_late", rx_busy, 1);
    tick();
    check("false_busy_lo", rx_busy, 0);
    idle(2 * C);
    check("false_ready", n_ready - r0, 0);
    check("false_ferr", n_ferr - f0, 0);

    // 0xA5 with inverted single-cycle glitch mid data bit 3
    r0 = n_ready;
    send_frame(8'hA5, 1'b1, 10, 4, H);
    idle(2 * C);
    check("glitch_count", n_ready - r0, 1);
    check("glitch_data", rx_data, 8'hA5);

    // good 0x3C, then 0xA5 with bad stop, then good 0x01
    send_frame(8'h3C, 1'b1, 10, -1, 0);
    idle(3 * C);
    check("b3c_data", rx_data, 8'h3C);
    r0 = n_ready; f0 = n_ferr;
    send_frame(8'hA5, 1'b0, 10, -1, 0);
    idle(3 * C);
    check("ferr_count", n_ferr - f0, 1);
    check("ferr_ready", n_ready - r0, 0);
    check("ferr_data_held", rx_data, 8'h3C);
    check("ferr_break", rx_break, 0);
    r0 = n_ready;
    send_frame(8'h01, 1'b1, 10, -1, 0);
    idle(2 * C);
    check("b01_count", n_ready - r0, 1);
    check("b01_data", rx_data, 8'h01);

    // line held low for 20 bit times
    x0 = cyc; r0 = n_ready; f0 = n_ferr;
    rx = 1'b0;
    for (int i = 0; i < 20 * C; i++) begin
      tick();
      if (cyc - x0 == 9 * C + H + 1 + SYNC) check("brk_before", rx_break, 0);
      if (cyc - x0 == 9 * C + H + 2 + SYNC) check("brk_rise", rx_break, 1);
    end
    check("brk_busy", rx_busy, 1);
    check("brk_ready", n_ready - r0, 0);
    check("brk_ferr", n_ferr - f0, 0);
    t0 = cyc;
    rx = 1'b1;
    while (cyc - t0 < C + SYNC - 1) tick();
    check("brk_hold", rx_break, 1);
    tick();
    check("brk_clear", rx_break, 0);
    check("brk_idle", rx_busy, 0);
    idle(C);

    // reset during data bit 4 of 0x7E
    r0 = n_ready;
    send_frame(8'h7E, 1'b1, 5, -1, 0);
    rx = 1'b1;
    repeat (4) tick();
    check("pre_rst_busy", rx_busy, 1);
    check("pre_rst_data", rx_data, 8'h01);
    rst_n = 1'b0;
    #1;
    check("rst_busy", rx_busy, 0);
    check("rst_data", rx_data, 8'h00);
    check("rst_ready", rx_ready, 0);
    check("rst_break", rx_break, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    idle(2 * C);
    check("rst_no_pulse", n_ready - r0, 0);

    // back-to-back 0x7E, 0x81
    got_q.delete();
    send_frame(8'h7E, 1'b1, 10, -1, 0);
    send_frame(8'h81, 1'b1, 10, -1, 0);
    idle(3 * C);
    check("b2b_count", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      check("b2b_first", got_q[0], 8'h7E);
      check("b2b_second", got_q[1], 8'h81);
    end

    check("pulse_overlap", n_both, 0);
    check("pulse_width", n_wide, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
